// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of a synchronous FIFO
//
// Shares one FIFO write port among NUM_REQ valid/ready requesters. Grants
// bursts of up to MAX_BURST beats, then rotates priority. A local credit
// counter tracks FIFO occupancy so the registered write path never overflows.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req_valid      per-requester beat valid
//   req_data       requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      combinational grant, at most one bit set
//   fifo_wr_en     registered FIFO write enable
//   fifo_din       registered FIFO write data
//   fifo_rd_en     consumer read enable (same signal driving the FIFO)
//   fifo_empty     FIFO empty flag
//   fifo_full      FIFO full flag, used only for overflow monitoring
//   occupancy      credit count: beats accepted minus beats popped
//   overflow_err   sticky error flag, cleared only by rst
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            fifo_wr_en,
   output logic [DATA_WIDTH-1:0]           fifo_din,
   input  logic                            fifo_rd_en,
   input  logic                            fifo_empty,
   input  logic                            fifo_full,
   output logic [$clog2(DEPTH+1)-1:0]      occupancy,
   output logic                            overflow_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   owner;
   logic [CNT_W-1:0]   beat_cnt;

   logic [IDX_W-1:0]   winner;
   logic               any_valid;
   logic [IDX_W-1:0]   grant_idx;
   logic               credit_ok;
   logic               accept;
   logic               pop;
   logic [DATA_WIDTH-1:0] acc_data;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) == NUM_REQ - 1)
         return '0;
      else
         return i + IDX_W'(1);
   endfunction

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      winner    = rr_ptr;
      any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int               pos;
         logic [IDX_W-1:0] cand;
         pos = int'(rr_ptr) + k;
         if (pos >= NUM_REQ)
            pos = pos - NUM_REQ;
         cand = IDX_W'(pos);
         if (!any_valid && req_valid[cand]) begin
            winner    = cand;
            any_valid = 1'b1;
         end
      end
   end

   assign credit_ok = (occupancy < OCC_W'(DEPTH));
   assign grant_idx = (state == IDLE) ? winner : owner;
   assign pop       = fifo_rd_en & ~fifo_empty;

   // In BURST the owner keeps the grant even with valid low; that cycle is
   // the gap that ends its burst.
   always_comb begin
      req_ready = '0;
      if (!rst && credit_ok && ((state == BURST) || any_valid))
         req_ready[grant_idx] = 1'b1;
   end

   assign accept   = |(req_valid & req_ready);
   assign acc_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner        <= '0;
         beat_cnt     <= '0;
         occupancy    <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_din     <= '0;
         overflow_err <= 1'b0;
      end else begin
         fifo_wr_en <= accept;
         if (accept)
            fifo_din <= acc_data;

         // Credit tracks accepts rather than FIFO writes, so the beat in the
         // write register is already counted.
         case ({accept, pop})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase

         if (fifo_wr_en && fifo_full && !pop)
            overflow_err <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  owner    <= winner;
                  beat_cnt <= CNT_W'(1);
                  if (MAX_BURST == 1)
                     rr_ptr <= next_idx(winner);
                  else
                     state <= BURST;
               end
            end
            BURST: begin
               if (req_valid[owner]) begin
                  if (credit_ok) begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                     if (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                        state  <= IDLE;
                        rr_ptr <= next_idx(owner);
                     end
                  end
               end else begin
                  state  <= IDLE;
                  rr_ptr <= next_idx(owner);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int NR    = 4;
   localparam int MB    = 4;
   localparam int OW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_ready;
   logic             fifo_wr_en;
   logic [DW-1:0]    fifo_din;
   logic             fifo_rd_en = 1'b0;
   logic             fifo_empty;
   logic             fifo_full;
   logic [OW-1:0]    occupancy;
   logic             overflow_err;

   fifo_wr_arbiter #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .occupancy(occupancy), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // FIFO flag model, reset by the same rst.
   int fifo_cnt = 0;
   assign fifo_empty = (fifo_cnt == 0);
   assign fifo_full  = (fifo_cnt == DEPTH);
   always @(posedge clk) begin
      if (rst)
         fifo_cnt <= 0;
      else
         fifo_cnt <= fifo_cnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fifo_cnt != 0) ? 1 : 0);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted beats are pushed when the handshake is seen and
   // popped when the FIFO write appears one cycle later.
   logic [DW-1:0] sb_q[$];
   logic          exp_wr = 1'b0;
   int            exp_occ = 0;
   logic [NR-1:0] last_acc = '0;

   always @(negedge clk) begin : monitor
      logic [NR-1:0] acc;
      logic          p;
      check("wr_en_latency", fifo_wr_en, exp_wr);
      if (fifo_wr_en) begin
         if (sb_q.size() == 0)
            check("sb_unexpected_write", 1'b1, 1'b0);
         else
            check("fifo_din", fifo_din, sb_q.pop_front());
      end
      check("occupancy", occupancy, exp_occ);
      check("grant_onehot", $onehot0(req_ready), 1'b1);
      acc      = req_valid & req_ready;
      p        = fifo_rd_en & ~fifo_empty;
      last_acc = acc;
      if (rst) begin
         exp_wr  = 1'b0;
         exp_occ = 0;
         sb_q.delete();
      end else begin
         exp_wr = |acc;
         for (int i = 0; i < NR; i++)
            if (acc[i])
               sb_q.push_back(req_data[i*DW +: DW]);
         exp_occ = exp_occ + int'(|acc) - int'(p);
      end
   end

   int seq[NR];

   task automatic drive_data();
      for (int i = 0; i < NR; i++)
         req_data[i*DW +: DW] = DW'(i * 64 + (seq[i] % 64));
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
         if (last_acc[i])
            seq[i]++;
      drive_data();
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      req_valid  = '0;
      fifo_rd_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [NR-1:0] valid;
      logic          rd;
      logic [NR-1:0] exp_ready;
   } vec_t;

   vec_t tbl[17];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;

      // All requesters valid, no reads: 4 beats each in rotation, then full.
      for (int v = 0; v < 17; v++) begin
         tbl[v].valid     = 4'b1111;
         tbl[v].rd        = 1'b0;
         tbl[v].exp_ready = (v < 16) ? NR'(1 << (v / MB)) : '0;
      end
      for (int i = 0; i < NR; i++) seq[i] = 1;
      drive_data();

      // Reset state
      tick();
      check("rst_ready", req_ready, '0);
      check("rst_occupancy", occupancy, 0);
      check("rst_wr_en", fifo_wr_en, 1'b0);
      check("rst_din", fifo_din, 0);
      check("rst_overflow", overflow_err, 1'b0);
      tick();
      rst = 1'b0;

      // Only req0 valid, data 1..10, accepted every cycle
      for (int i = 0; i < NR; i++) seq[i] = 1;
      drive_data();
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("t1_ready", req_ready, 4'b0001);
         tick();
      end
      check("t1_last_wr", fifo_wr_en, 1'b1);
      check("t1_last_din", fifo_din, 8'd10);
      req_valid = '0;
      tick();

      do_reset();
      for (int v = 0; v < 17; v++) begin
         req_valid  = tbl[v].valid;
         fifo_rd_en = tbl[v].rd;
         #1;
         check($sformatf("t2_ready[%0d]", v), req_ready, tbl[v].exp_ready);
         tick();
      end
      check("t2_occupancy", occupancy, 16);
      check("t2_fifo_full", fifo_full, 1'b1);
      check("t2_overflow", overflow_err, 1'b0);
      check("t2_ready_full", req_ready, '0);

      // One pop from full lets exactly one more beat in, from req0
      fifo_rd_en = 1'b1;
      #1;
      check("t3_ready_during_pop", req_ready, '0);
      tick();
      fifo_rd_en = 1'b0;
      check("t3_occ_after_pop", occupancy, 15);
      #1;
      check("t3_one_more", req_ready, 4'b0001);
      tick();
      check("t3_occ_refill", occupancy, 16);
      #1;
      check("t3_ready_full_again", req_ready, '0);
      tick();
      check("t3_occ_hold", occupancy, 16);
      check("t3_overflow", overflow_err, 1'b0);

      // Owner req2 drops after 2 beats; next grant goes to req3
      do_reset();
      req_valid = 4'b0100;
      #1;
      check("t4_beat1", req_ready, 4'b0100);
      tick();
      #1;
      check("t4_beat2", req_ready, 4'b0100);
      tick();
      req_valid = 4'b1001;
      #1;
      check("t4_gap_noacc", req_valid & req_ready, '0);
      tick();
      #1;
      check("t4_next_grant", req_ready, 4'b1000);
      tick();

      // Accept and pop together at occupancy 8
      budget = 40;
      while (occupancy != 8 && budget > 0) begin
         tick();
         budget--;
      end
      check("t5_reach_8", occupancy, 8);
      fifo_rd_en = 1'b1;
      #1;
      check("t5_accepting", |(req_valid & req_ready), 1'b1);
      check("t5_not_empty", fifo_empty, 1'b0);
      tick();
      fifo_rd_en = 1'b0;
      check("t5_occ_same", occupancy, 8);
      check("t5_wr_en", fifo_wr_en, 1'b1);
      req_valid = '0;
      tick();

      // Reset mid-burst (owner req1, 2 beats in)
      do_reset();
      req_valid = 4'b0010;
      tick();
      tick();
      rst       = 1'b1;
      req_valid = 4'b0011;
      #1;
      check("t6_ready_in_rst", req_ready, '0);
      tick();
      rst = 1'b0;
      check("t6_occupancy", occupancy, 0);
      check("t6_wr_en_dropped", fifo_wr_en, 1'b0);
      #1;
      check("t6_req0_wins", req_ready, 4'b0001);
      tick();
      check("t6_wr_en", fifo_wr_en, 1'b1);
      check("t6_din_src", fifo_din[7:6], 2'd0);
      req_valid = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
